lpm_table_ctrl: RTL and testbench
=================================

// Module: lpm_table_ctrl
// PURPOSE
//  Owns the 32-entry LPM route table and serialises all access to it: datapath
//  lookups from the output-port-lookup stage, and register-side table reads and
//  writes. One table access per cycle; lookup is a first-match linear scan, so
//  software keeps entries sorted longest-prefix first. Drives the lookup
//  stage's hit / next-hop / output-queue inputs.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32   register word width; entry = 4 words = 128 bits
//  NUM_ENTRIES         32   table depth; index width = log2(NUM_ENTRIES) = 5
// PORTS
//  AXI_ACLK        in   1    clock
//  reset           in   1    sync reset, active-high
//  lkp_req         in   1    lookup request; level, held until lkp_done
//  lkp_ip          in   32   destination IP; stable while lkp_req high
//  lkp_done        out  1    one-cycle pulse: lookup result valid
//  lkp_hit         out  1    match found
//  lkp_nh          out  32   next hop of matching entry (0 on miss)
//  lkp_oq          out  32   output queue of matching entry (0 on miss)
//  tbl_rd_req      in   1    table read request; level, held until tbl_rd_ack
//  tbl_rd_addr     in   5    entry to read
//  tbl_rd_data     out  128  entry contents, valid with tbl_rd_ack
//  tbl_rd_ack      out  1    one-cycle pulse
//  tbl_wr_req      in   1    table write request; level, held until tbl_wr_ack
//  tbl_wr_addr     in   5    entry to write
//  tbl_wr_data     in   128  new entry contents
//  tbl_wr_ack      out  1    one-cycle pulse; write committed this cycle
//  miss_count      out  32   lookups that missed; wraps 0xFFFFFFFF -> 0
//  miss_count_clr  in   1    synchronous clear of miss_count
// BEHAVIOUR
//  - Entry layout: [31:0] prefix, [63:32] mask, [95:64] next hop, [127:96] oq.
//    Entry invalid iff oq field == 32'hFFFFFFFF. Match: valid &&
//    (lkp_ip & mask) == (prefix & mask). Mask 0 = default route, matches all.
//  - Reset: every entry 128'hFFFF..FF (all invalid); FSM IDLE; all outputs 0,
//    including miss_count, tbl_rd_data, lkp_nh, lkp_oq.
//  - FSM: IDLE, SCAN, DONE, RD, WR.
//  - IDLE arbitration:
//    - Flag last_cpu is set when RD/WR is granted, cleared when SCAN is granted.
//    - If last_cpu && lkp_req -> SCAN.
//    - Else priority tbl_wr_req -> WR, then tbl_rd_req -> RD, then lkp_req -> SCAN.
//    - Effect: a pending lookup waits at most one CPU access.
//  - SCAN: index starts at 0, one entry per cycle. On match at index k -> DONE
//    with hit, nh, oq captured. If index 31 does not match -> DONE with miss.
//    Scan is atomic: no CPU access is granted until it completes.
//  - DONE (one cycle): lkp_done=1. lkp_hit/nh/oq are registered, and hold
//    until the next DONE. On a miss, miss_count increments.
//  - RD (one cycle): tbl_rd_data <= table[tbl_rd_addr]; tbl_rd_ack=1.
//  - WR (one cycle): table[tbl_wr_addr] <= tbl_wr_data; tbl_wr_ack=1.
//  - Every state other than IDLE returns to IDLE.
//  - Ack rule: requesters deassert req on the edge at which ack/done is sampled.
//    A req still high in the following IDLE is treated as a new request.
//  - Latency (grant in IDLE at cycle T):
//    - hit at index k: lkp_done at T+2+k;
//    - miss: lkp_done at T+33;
//    - RD/WR: ack at T+1.
//    - Lookup worst case (one CPU access ahead of it): 35 cycles from req.
//  - miss_count: clr has priority over a same-cycle increment; the result is 0.
//  - Reset mid-scan: FSM goes to IDLE, no lkp_done, table reinitialised, last_cpu=0.
//  - Write/read address 31 and index wrap: index never exceeds 31. Out-of-range
//    addresses cannot occur (5-bit).
// TESTING
//  1. After reset, lkp_ip=10.0.0.1 -> lkp_done at T+33, hit=0, nh=oq=0,
//     miss_count=1.
//  2. Write entry 3 = {oq=2, nh=10.0.0.254, mask=FFFFFF00, prefix=10.0.0.0},
//     read it back (exact 128-bit match). Then lookup 10.0.0.77 -> done at
//     T+5, hit=1, nh=0x0A0000FE, oq=2.
//  3. Entry 0 = /24 oq=1, entry 5 = /0 default oq=4:
//     lookup 10.0.0.9 -> oq=1; lookup 192.168.1.1 -> oq=4, done at T+7.
//  4. tbl_wr_req, tbl_rd_req, lkp_req asserted in the same cycle:
//     order WR, SCAN, RD. The lookup observes the new entry.
//  5. Set miss_count=0xFFFFFFFF via misses, then one miss -> 0. Miss coinciding
//     with miss_count_clr -> 0.
//  6. Reset asserted at scan index 10 -> no lkp_done. A subsequent lookup misses
//     even for IPs the pre-reset table matched.

Source files
------------

// File: rtl/lpm_table_ctrl_if.sv
// Lookup, table read/write and miss-counter signals between the LPM table
// controller (slave) and the lookup stage / register block (master).
interface lpm_table_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic            lkp_req;
  logic [DW-1:0]   lkp_ip;
  logic            lkp_done;
  logic            lkp_hit;
  logic [DW-1:0]   lkp_nh;
  logic [DW-1:0]   lkp_oq;
  logic            tbl_rd_req;
  logic [AW-1:0]   tbl_rd_addr;
  logic [4*DW-1:0] tbl_rd_data;
  logic            tbl_rd_ack;
  logic            tbl_wr_req;
  logic [AW-1:0]   tbl_wr_addr;
  logic [4*DW-1:0] tbl_wr_data;
  logic            tbl_wr_ack;
  logic [DW-1:0]   miss_count;
  logic            miss_count_clr;

  modport master (
    output lkp_req, lkp_ip, tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr,
           tbl_wr_data, miss_count_clr,
    input  lkp_done, lkp_hit, lkp_nh, lkp_oq, tbl_rd_data, tbl_rd_ack,
           tbl_wr_ack, miss_count
  );

  modport slave (
    input  lkp_req, lkp_ip, tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr,
           tbl_wr_data, miss_count_clr,
    output lkp_done, lkp_hit, lkp_nh, lkp_oq, tbl_rd_data, tbl_rd_ack,
           tbl_wr_ack, miss_count
  );
endinterface

// File: rtl/lpm_table_ctrl.sv
// LPM route table owner: arbitrates first-match linear-scan lookups against
// register-side entry reads/writes, one table access per cycle.
module lpm_table_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_ENTRIES        = 32
) (
  input  logic          AXI_ACLK,
  input  logic          reset,
  lpm_table_ctrl_if.slave bus
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int EW = 4 * DW;
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_cpu_q, last_cpu_d;
  logic          hit_q, hit_d;
  logic [DW-1:0] nh_q, nh_d;
  logic [DW-1:0] oq_q, oq_d;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] miss_q, miss_d;
  logic [EW-1:0] tbl_q [NUM_ENTRIES];
  logic [EW-1:0] tbl_d [NUM_ENTRIES];

  logic [EW-1:0] cur_entry;
  logic [DW-1:0] cur_prefix, cur_mask, cur_nh, cur_oq;
  logic          cur_match;
  logic          miss_inc;

  assign cur_entry  = tbl_q[idx_q];
  assign cur_prefix = cur_entry[DW-1:0];
  assign cur_mask   = cur_entry[2*DW-1:DW];
  assign cur_nh     = cur_entry[3*DW-1:2*DW];
  assign cur_oq     = cur_entry[4*DW-1:3*DW];
  // An all-ones output queue marks the slot as empty.
  assign cur_match  = (cur_oq != '1) &&
                      ((bus.lkp_ip & cur_mask) == (cur_prefix & cur_mask));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_cpu_d = last_cpu_q;
    hit_d      = hit_q;
    nh_d       = nh_q;
    oq_d       = oq_q;
    rd_data_d  = rd_data_q;
    tbl_d      = tbl_q;
    miss_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lookup that lost to a CPU access wins the next arbitration.
        if (last_cpu_q && bus.lkp_req) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          last_cpu_d = 1'b0;
        end else if (bus.tbl_wr_req) begin
          state_d    = ST_WR;
          last_cpu_d = 1'b1;
        end else if (bus.tbl_rd_req) begin
          state_d    = ST_RD;
          last_cpu_d = 1'b1;
          rd_data_d  = tbl_q[bus.tbl_rd_addr];
        end else if (bus.lkp_req) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          last_cpu_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cur_match) begin
          state_d = ST_DONE;
          hit_d   = 1'b1;
          nh_d    = cur_nh;
          oq_d    = cur_oq;
        end else if (idx_q == LAST_IDX) begin
          state_d  = ST_DONE;
          hit_d    = 1'b0;
          nh_d     = '0;
          oq_d     = '0;
          miss_inc = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_WR: begin
        tbl_d[bus.tbl_wr_addr] = bus.tbl_wr_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.miss_count_clr) begin
      miss_d = '0;
    end else if (miss_inc) begin
      miss_d = miss_q + DW'(1);
    end else begin
      miss_d = miss_q;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_cpu_q <= 1'b0;
      hit_q      <= 1'b0;
      nh_q       <= '0;
      oq_q       <= '0;
      rd_data_q  <= '0;
      miss_q     <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_q[i] <= '1;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_cpu_q <= last_cpu_d;
      hit_q      <= hit_d;
      nh_q       <= nh_d;
      oq_q       <= oq_d;
      rd_data_q  <= rd_data_d;
      miss_q     <= miss_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign bus.lkp_done    = (state_q == ST_DONE);
  assign bus.lkp_hit     = hit_q;
  assign bus.lkp_nh      = nh_q;
  assign bus.lkp_oq      = oq_q;
  assign bus.tbl_rd_data = rd_data_q;
  assign bus.tbl_rd_ack  = (state_q == ST_RD);
  assign bus.tbl_wr_ack  = (state_q == ST_WR);
  assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_lpm_table_ctrl.sv
// Directed and randomized checks of lpm_table_ctrl against a linear-scan
// route table model kept in the bench.
module tb_lpm_table_ctrl;
  logic AXI_ACLK = 1'b0;
  logic reset    = 1'b1;
  always #5 AXI_ACLK = ~AXI_ACLK;

  lpm_table_ctrl_if #(.DW(32), .AW(5)) bus ();

  lpm_table_ctrl dut (
    .AXI_ACLK(AXI_ACLK),
    .reset   (reset),
    .bus     (bus)
  );

  logic [127:0] m_tbl [32];
  logic [31:0]  m_miss;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_ACLK);
    #1;
  endtask

  function automatic logic [31:0] len_mask(input int len);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (len == 0) ? 32'h0 : (ones << (32 - len));
  endfunction

  function automatic logic [127:0] mk_entry(input logic [31:0] oq, input logic [31:0] nh,
                                            input logic [31:0] mask, input logic [31:0] pfx);
    return {oq, nh, mask, pfx};
  endfunction

  // Reference: first valid entry whose masked prefix equals the masked IP.
  task automatic model_lookup(input logic [31:0] ip, output logic hit, output int k,
                              output logic [31:0] nh, output logic [31:0] oq);
    hit = 1'b0; k = 0; nh = 32'h0; oq = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (!hit && m_tbl[i][127:96] != 32'hFFFF_FFFF &&
          ((ip & m_tbl[i][63:32]) == (m_tbl[i][31:0] & m_tbl[i][63:32]))) begin
        hit = 1'b1; k = i; nh = m_tbl[i][95:64]; oq = m_tbl[i][127:96];
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_tbl[i] = '1;
    m_miss = 32'h0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.lkp_req = 1'b0; bus.lkp_ip = '0;
    bus.tbl_rd_req = 1'b0; bus.tbl_rd_addr = '0;
    bus.tbl_wr_req = 1'b0; bus.tbl_wr_addr = '0; bus.tbl_wr_data = '0;
    bus.miss_count_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic tbl_write(input logic [4:0] addr, input logic [127:0] data);
    int n = 0;
    bus.tbl_wr_addr = addr; bus.tbl_wr_data = data; bus.tbl_wr_req = 1'b1;
    while (n < 50 && !bus.tbl_wr_ack) begin tick(); n++; end
    bus.tbl_wr_req = 1'b0;
    chk("wr_latency", 128'(n), 128'(1));
    m_tbl[addr] = data;
    tick();
  endtask

  task automatic tbl_read(input logic [4:0] addr);
    int n = 0;
    bus.tbl_rd_addr = addr; bus.tbl_rd_req = 1'b1;
    while (n < 50 && !bus.tbl_rd_ack) begin tick(); n++; end
    bus.tbl_rd_req = 1'b0;
    chk("rd_latency", 128'(n), 128'(1));
    chk("rd_data", bus.tbl_rd_data, m_tbl[addr]);
    tick();
  endtask

  task automatic lookup(input logic [31:0] ip, input logic clr_hold);
    logic e_hit; int e_k; logic [31:0] e_nh, e_oq;
    int n = 0;
    model_lookup(ip, e_hit, e_k, e_nh, e_oq);
    bus.lkp_ip = ip; bus.lkp_req = 1'b1; bus.miss_count_clr = clr_hold;
    while (n < 100 && !bus.lkp_done) begin tick(); n++; end
    bus.lkp_req = 1'b0;
    if (clr_hold) m_miss = 32'h0;
    else if (!e_hit) m_miss = m_miss + 32'h1;
    chk("lkp_latency", 128'(n), e_hit ? 128'(2 + e_k) : 128'(33));
    chk("lkp_hit", 128'(bus.lkp_hit), 128'(e_hit));
    chk("lkp_nh", 128'(bus.lkp_nh), 128'(e_nh));
    chk("lkp_oq", 128'(bus.lkp_oq), 128'(e_oq));
    chk("miss_count", 128'(bus.miss_count), 128'(m_miss));
    bus.miss_count_clr = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] pool [4];
    int lens [5];
    logic e_hit; int e_k; logic [31:0] e_nh, e_oq;
    int n, wr_n, rd_n, dn_n;
    logic got_hit; logic [31:0] got_oq;

    pool[0] = 32'h0A00_0000; pool[1] = 32'hC0A8_0100;
    pool[2] = 32'hAC10_0000; pool[3] = 32'hC633_6400;
    lens[0] = 0; lens[1] = 8; lens[2] = 16; lens[3] = 24; lens[4] = 32;

    apply_reset();
    chk("rst_done", 128'(bus.lkp_done), 128'(0));
    chk("rst_hit", 128'(bus.lkp_hit), 128'(0));
    chk("rst_nh_oq", 128'({bus.lkp_nh, bus.lkp_oq}), 128'(0));
    chk("rst_rd_data", bus.tbl_rd_data, 128'(0));
    chk("rst_miss", 128'(bus.miss_count), 128'(0));
    chk("rst_acks", 128'({bus.tbl_rd_ack, bus.tbl_wr_ack}), 128'(0));

    // Empty table: every lookup misses after a full scan.
    lookup(32'h0A00_0001, 1'b0);

    // Single /24 entry at index 3, read back and hit.
    tbl_write(5'd3, mk_entry(32'd2, 32'h0A00_00FE, 32'hFFFF_FF00, 32'h0A00_0000));
    tbl_read(5'd3);
    chk("entry3_exact", bus.tbl_rd_data, 128'h00000002_0A0000FE_FFFFFF00_0A000000);
    lookup(32'h0A00_004D, 1'b0);

    // Specific route ahead of a default route.
    tbl_write(5'd0, mk_entry(32'd1, 32'h0A00_0001, 32'hFFFF_FF00, 32'h0A00_0000));
    tbl_write(5'd5, mk_entry(32'd4, 32'hC0A8_01FE, 32'h0, 32'h0));
    lookup(32'h0A00_0009, 1'b0);
    lookup(32'hC0A8_0101, 1'b0);

    // Three simultaneous requesters: write, then the lookup, then the read.
    bus.tbl_wr_addr = 5'd1;
    bus.tbl_wr_data = mk_entry(32'd7, 32'hAC10_00FE, 32'hFFFF_0000, 32'hAC10_0000);
    bus.tbl_rd_addr = 5'd3;
    bus.lkp_ip = 32'hAC10_0505;
    bus.tbl_wr_req = 1'b1; bus.tbl_rd_req = 1'b1; bus.lkp_req = 1'b1;
    n = 0; wr_n = 0; rd_n = 0; dn_n = 0; got_hit = 1'b0; got_oq = '0;
    while (n < 100 && (wr_n == 0 || rd_n == 0 || dn_n == 0)) begin
      tick(); n++;
      if (bus.tbl_wr_ack) begin wr_n = n; bus.tbl_wr_req = 1'b0; end
      if (bus.tbl_rd_ack) begin
        rd_n = n; bus.tbl_rd_req = 1'b0;
        chk("arb_rd_data", bus.tbl_rd_data, m_tbl[3]);
      end
      if (bus.lkp_done) begin
        dn_n = n; bus.lkp_req = 1'b0; got_hit = bus.lkp_hit; got_oq = bus.lkp_oq;
      end
    end
    m_tbl[1] = mk_entry(32'd7, 32'hAC10_00FE, 32'hFFFF_0000, 32'hAC10_0000);
    model_lookup(32'hAC10_0505, e_hit, e_k, e_nh, e_oq);
    chk("arb_wr_cycle", 128'(wr_n), 128'(1));
    chk("arb_lkp_cycle", 128'(dn_n), 128'(4 + e_k));
    chk("arb_rd_cycle", 128'(rd_n), 128'(6 + e_k));
    chk("arb_lkp_hit", 128'(got_hit), 128'(e_hit));
    chk("arb_lkp_oq", 128'(got_oq), 128'(e_oq));
    tick();

    // Counter clear alone, then a miss with clear held through it.
    lookup(32'h0808_0808, 1'b0);
    tbl_write(5'd5, '1);
    lookup(32'h0808_0808, 1'b0);
    bus.miss_count_clr = 1'b1; tick(); bus.miss_count_clr = 1'b0; m_miss = 32'h0;
    chk("miss_clr", 128'(bus.miss_count), 128'(0));
    lookup(32'h0808_0808, 1'b0);
    lookup(32'h0808_0809, 1'b1);

    // Randomized mix of writes, reads and lookups.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: tbl_write(5'($urandom_range(0, 31)),
                     mk_entry(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15)),
                              $urandom, len_mask(lens[$urandom_range(0, 4)]),
                              pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 255))));
        1: tbl_read(5'($urandom_range(0, 31)));
        default: lookup(($urandom_range(0, 3) == 0) ? $urandom
                        : (pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 255))), 1'b0);
      endcase
    end

    // Reset in the middle of a scan.
    apply_reset();
    tbl_write(5'd20, mk_entry(32'd3, 32'hC633_64FE, 32'hFFFF_FF00, 32'hC633_6400));
    tbl_write(5'd31, mk_entry(32'd9, 32'h0102_0304, 32'hFFFF_FFFF, 32'h0909_0909));
    tbl_read(5'd31);
    lookup(32'hC633_6407, 1'b0);
    lookup(32'h0909_0909, 1'b0);
    bus.lkp_ip = 32'hC633_6407; bus.lkp_req = 1'b1;
    n = 0; dn_n = 0;
    for (int c = 0; c < 11; c++) begin tick(); n++; if (bus.lkp_done) dn_n = n; end
    reset = 1'b1; bus.lkp_req = 1'b0;
    for (int c = 0; c < 3; c++) begin tick(); if (bus.lkp_done) dn_n = 99; end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin tick(); if (bus.lkp_done) dn_n = 99; end
    chk("rst_mid_no_done", 128'(dn_n), 128'(0));
    chk("rst_mid_outputs", 128'({bus.lkp_hit, bus.lkp_nh, bus.lkp_oq}), 128'(0));
    chk("rst_mid_miss", 128'(bus.miss_count), 128'(0));
    tbl_read(5'd20);
    lookup(32'hC633_6407, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
